// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 decryption, one inverse round per clock
// Ports: clk, rst (sync, active-high); in_valid/in_ready + ciphertext/cipher_key accept a block;
// out_valid/out_ready + plaintext return it; busy is high outside IDLE.
// Optional: define AES_DEC_KEY_CACHE_EN to reuse the last expanded round-10 key when the cipher key repeats.
module aes_decrypt_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] cipher_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL, DONE} fsm_t;
  fsm_t fsm;
  logic [127:0] blk, key, isb, fin_out, rnd_out, kexp_nxt, kinv_nxt, hit_k10;
  logic [7:0] rcon, rcon_back;
  logic [3:0] cnt;
  logic hit;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  // multiplicative inverse as a^254; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] s, r;
    s = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction
  function automatic logic [31:0] rot_sub(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ rot_sub(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ rot_sub(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b) ^
                               gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction
  // byte i sits at row i%4, column i/4; InvShiftRows rotates row r right by r
  always_comb begin
    isb = '0;
    for (int i = 0; i < 16; i++)
      isb[127-8*i -: 8] = inv_sbox(blk[127-8*((i%4)+4*((i/4+4-i%4)%4)) -: 8]);
  end
  assign fin_out   = isb ^ key;
  assign rnd_out   = inv_mix(fin_out);
  assign kexp_nxt  = fwd_key(key, rcon);
  assign kinv_nxt  = inv_key(key, rcon);
  assign rcon_back = (rcon == 8'h1b) ? 8'h80 : rcon >> 1;
`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key, cache_k10;
  logic cache_vld;
  assign hit     = cache_vld && cipher_key == cache_key;
  assign hit_k10 = cache_k10;
  // a miss drops the valid flag until its own expansion completes
  always_ff @(posedge clk)
    if (rst) cache_vld <= 1'b0;
    else if (fsm == IDLE && in_valid && !hit) begin
      cache_vld <= 1'b0;
      cache_key <= cipher_key;
    end else if (fsm == KEXP && cnt == 4'd9) begin
      cache_vld <= 1'b1;
      cache_k10 <= kexp_nxt;
    end
`else
  assign hit     = 1'b0;
  assign hit_k10 = '0;
`endif
  // the inverse key step runs in INIT too, so ROUND r always finds k_r in the key register
  always_ff @(posedge clk)
    if (rst) begin
      fsm       <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      plaintext <= '0;
      cnt       <= 4'd0;
      rcon      <= 8'h01;
    end else
      case (fsm)
        IDLE: if (in_valid) begin
          blk      <= ciphertext;
          key      <= hit ? hit_k10 : cipher_key;
          rcon     <= hit ? 8'h36 : 8'h01;
          cnt      <= 4'd0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          fsm      <= hit ? INIT : KEXP;
        end
        KEXP: begin
          key  <= kexp_nxt;
          rcon <= (cnt == 4'd9) ? rcon : xt(rcon);
          cnt  <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
          fsm  <= (cnt == 4'd9) ? INIT : KEXP;
        end
        INIT: begin
          blk  <= blk ^ key;
          key  <= kinv_nxt;
          rcon <= rcon_back;
          fsm  <= ROUND;
        end
        ROUND: begin
          blk  <= rnd_out;
          key  <= kinv_nxt;
          rcon <= rcon_back;
          cnt  <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
          fsm  <= (cnt == 4'd8) ? FINAL : ROUND;
        end
        FINAL: begin
          plaintext <= fin_out;
          out_valid <= 1'b1;
          fsm       <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb_aes_decrypt_core: randomized self-checking bench against a table-driven AES-128 encryption model
module tb_aes_decrypt_core;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] ciphertext, cipher_key, plaintext;
  int checks = 0, errors = 0;
  logic [7:0] sb [256];
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 21;
`endif
  aes_decrypt_core dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .cipher_key(cipher_key), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  // walk the multiplicative group by generator 3 and its inverse by 3^-1
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask
  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]] ^ rc, sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4)+4*(((i/4)+(i%4))%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // offer a block until accepted (bounded); inputs are scrambled right after the accept edge
  task automatic offer(input logic [127:0] k, input logic [127:0] c, output bit ok);
    cipher_key = k;
    ciphertext = c;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cipher_key = rand128();
    ciphertext = rand128();
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cipher_key = '0;
    ciphertext = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (plaintext !== 128'h0) begin errors++; $display("FAIL reset_plaintext: got %h want 0", plaintext); end
  endtask
  task automatic test_fips_c1();
    bit ok;
    int lat;
    offer(C1_KEY, C1_CT, ok);
    checks++; if (!ok) begin errors++; $display("FAIL c1_accept: got no accept want accept"); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL c1_busy: got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    wait_out(lat);
    checks++; if (lat !== 21) begin errors++; $display("FAIL c1_latency: got %0d want 21", lat); end
    checks++; if (plaintext !== C1_PT) begin errors++; $display("FAIL c1_plaintext: got %h want %h", plaintext, C1_PT); end
    take();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL c1_release: got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
  endtask
  // in_valid garbage and early out_ready during the computation must not disturb it
  task automatic test_fips_b();
    bit ok;
    int lat;
    logic [127:0] k10;
    offer(B_KEY, B_CT, ok);
    lat = 0;
    k10 = '0;
    while (!out_valid && lat < 300) begin
      if (lat == 10) k10 = dut.key;
      in_valid = 1'($urandom_range(0, 1));
      ciphertext = rand128();
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (k10 !== B_K10) begin errors++; $display("FAIL b_k10: got %h want %h", k10, B_K10); end
    checks++; if (lat !== 21) begin errors++; $display("FAIL b_latency: got %0d want 21", lat); end
    checks++; if (plaintext !== B_PT) begin errors++; $display("FAIL b_plaintext: got %h want %h", plaintext, B_PT); end
    take();
  endtask
  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [127:0] k, pt;
    k = rand128();
    pt = rand128();
    offer(k, aes_enc(k, pt), ok);
    wait_out(lat);
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      ciphertext = rand128();
      @(posedge clk); #1;
      checks++;
      if (plaintext !== pt || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got pt=%h ov=%b ir=%b want pt=%h ov=1 ir=0", i, plaintext, out_valid, in_ready, pt);
      end
    end
    in_valid = 1'b0;
    take();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask
  // reset during the ninth inverse round; the C.1 key was just expanded so a surviving cache would show as latency 11
  task automatic test_reset_mid_round();
    bit ok;
    int lat;
    offer(C1_KEY, rand128(), ok);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
    checks++; if (plaintext !== 128'h0) begin errors++; $display("FAIL mid_reset_plaintext: got %h want 0", plaintext); end
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_no_output: got %b want 0", out_valid); end
    offer(C1_KEY, C1_CT, ok);
    wait_out(lat);
    checks++; if (lat !== 21) begin errors++; $display("FAIL mid_reset_latency: got %0d want 21", lat); end
    checks++; if (plaintext !== C1_PT) begin errors++; $display("FAIL mid_reset_plaintext2: got %h want %h", plaintext, C1_PT); end
    take();
  endtask
  task automatic test_back_to_back();
    bit ok;
    int lat;
    logic [127:0] k, p0, p1;
    k = rand128();
    p0 = rand128();
    p1 = rand128();
    offer(k, aes_enc(k, p0), ok);
    wait_out(lat);
    checks++; if (lat !== 21) begin errors++; $display("FAIL b2b_lat0: got %0d want 21", lat); end
    checks++; if (plaintext !== p0) begin errors++; $display("FAIL b2b_pt0: got %h want %h", plaintext, p0); end
    take();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_bubble: got %b want 1", in_ready); end
    offer(k, aes_enc(k, p1), ok);
    wait_out(lat);
    checks++; if (lat !== HIT_LAT) begin errors++; $display("FAIL b2b_lat1: got %0d want %0d", lat, HIT_LAT); end
    checks++; if (plaintext !== p1) begin errors++; $display("FAIL b2b_pt1: got %h want %h", plaintext, p1); end
    take();
  endtask
  task automatic test_random();
    bit ok;
    int lat;
    logic [127:0] k, pt, prev;
    prev = rand128();
    for (int n = 0; n < 1000; n++) begin
      k = ($urandom_range(0, 3) == 0) ? prev : rand128();
      prev = k;
      pt = rand128();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      offer(k, aes_enc(k, pt), ok);
      wait_out(lat);
      checks++;
      if (plaintext !== pt || !ok || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d]: got %h ov=%b want %h ov=1", n, plaintext, out_valid, pt);
      end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      take();
    end
  endtask
  initial begin
    build_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_backpressure();
    test_reset_mid_round();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
